counter_mod10: RTL and testbench
================================

Name: counter_mod10

Overview:
- Synchronous 4-bit BCD down-counter, modulo 10, for one digit of the microwave MS timer.
- Supports parallel load, hold and synchronous clear.
- Provides a terminal-count output for cascading to the next digit, and a zero flag for end-of-time detection.
- One instance per decimal digit; tc_saida of a lower digit drives enab of the next higher digit.

Parameters:
- MODULUS, 10, number of count states (0..MODULUS-1); counter wraps 0 -> MODULUS-1.
- WIDTH, 4, width of the count and load buses; must satisfy 2**WIDTH >= MODULUS.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- clear  input  1  synchronous reset, active-high; forces the count to 0.
- load  input  1  synchronous parallel load, active-low.
- enab  input  1  count enable, active-high; decrements by one per rising edge.
- numero  input  WIDTH  parallel load value.
- numero_saida  output  WIDTH  current count, registered.
- tc_saida  output  1  terminal count (borrow), combinational.
- zero_saida  output  1  count-equals-zero flag, combinational from the register.

Behaviour:
- Register priority on each rising clk edge, highest first:
  1. clear==1 -> count <= 0.
  2. else load==0 -> count <= numero; if numero > MODULUS-1, count <= MODULUS-1 (saturating load, no illegal states).
  3. else enab==1 -> if count==0 then count <= MODULUS-1 (wrap), else count <= count-1.
  4. else hold.
- Reset value: numero_saida = 0, zero_saida = 1, tc_saida = enab (0 when enab=0).
- Latency:
  - Load and count take effect on the same rising edge; visible on numero_saida immediately after that edge.
  - Flags follow the register with no extra cycle.
- tc_saida = enab AND (count==0). Purely combinational, no register. A cascaded higher digit therefore decrements on the same edge on which this digit wraps 0 -> 9.
- zero_saida = (count==0), independent of enab, load and clear inputs.
- Simultaneous events:
  - clear with load or enab: clear wins.
  - load with enab: load wins, no decrement that cycle.
- Load and count are ignored between edges; no asynchronous paths on any input.
- The count never leaves 0..MODULUS-1.
- Asserting clear mid-count returns to 0 on the next edge. Counting resumes from 0 (next enabled edge -> 9) once clear drops.
- enab=0 freezes the count indefinitely; tc_saida is 0 while enab=0.

Test Plan:
- Reset: clear=1 for 2 edges, load=1, enab=1 -> numero_saida=0, zero_saida=1, tc_saida=1. Then drop enab -> tc_saida=0.
- Load then count down: load=0, numero=5 for one edge. Then load=1, enab=1 for 5 edges -> numero_saida 4,3,2,1,0. zero_saida=1 and tc_saida=1 only after the 5th edge; zero_saida=0 before.
- Wrap and hold: from 0 with enab=1, one edge -> numero_saida=9, zero_saida=0, tc_saida=0. Then enab=0 for 3 edges -> stays 9.
- Full cycle: from 9, 10 enabled edges -> 8..0 then 9. tc_saida high exactly during the cycle count==0.
- Saturating load: load=0, numero=4'b1100 -> numero_saida=9. numero=4'b1111 -> 9.
- Priority: on one edge apply clear=1, load=0, numero=7, enab=1 -> 0. Then load=0, numero=3, enab=1 -> 3 (no decrement).

Source files
------------

// File: rtl/counter_mod10.sv
// One BCD digit of the timer: a modulo-MODULUS down-counter with parallel load and borrow output.
// Digits cascade by wiring tc_saida of the lower digit to enab of the next higher digit.
module counter_mod10 #(
   parameter int unsigned MODULUS = 10,
   parameter int unsigned WIDTH   = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic             enab,
   input  logic [WIDTH-1:0] numero,
   output logic [WIDTH-1:0] numero_saida,
   output logic             tc_saida,
   output logic             zero_saida
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             count_is_zero;

   assign count_is_zero = (count_q == '0);

   // Loads above MaxVal saturate so the register never holds an illegal digit.
   always_comb begin
      count_d = count_q;
      if (!load) begin
         count_d = (numero > MaxVal) ? MaxVal : numero;
      end else if (enab) begin
         count_d = count_is_zero ? MaxVal : count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign numero_saida = count_q;
   assign zero_saida   = count_is_zero;
   // Borrow is combinational so the next digit decrements on the same edge this one wraps.
   assign tc_saida     = enab & count_is_zero;

endmodule

// File: tb/tb_counter_mod10.sv
// Self-checking bench for counter_mod10: directed test-plan steps followed by randomized
// stimulus, all compared against an arithmetic model of one decimal digit.
module tb_counter_mod10;

   localparam int M = 10;
   localparam int W = 4;

   logic         clk;
   logic         clear;
   logic         load;
   logic         enab;
   logic [W-1:0] numero;
   logic [W-1:0] numero_saida;
   logic         tc_saida;
   logic         zero_saida;

   int checks   = 0;
   int failures = 0;
   int model    = 0;
   int tc_seen  = 0;

   counter_mod10 #(
      .MODULUS(M),
      .WIDTH  (W)
   ) dut (
      .clk         (clk),
      .clear       (clear),
      .load        (load),
      .enab        (enab),
      .numero      (numero),
      .numero_saida(numero_saida),
      .tc_saida    (tc_saida),
      .zero_saida  (zero_saida)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Next digit value derived from the behavioural rules in plain arithmetic.
   function automatic int next_digit(input int cur, input bit c, input bit l, input bit e,
                                     input int n);
      if (c) return 0;
      if (!l) return (n < M) ? n : M - 1;
      if (e) return (cur + M - 1) % M;
      return cur;
   endfunction

   // Drive inputs, check the borrow before the edge, clock once, then check everything after.
   task automatic step(input string tag, input bit c, input bit l, input bit e, input int n);
      clear  = c;
      load   = l;
      enab   = e;
      numero = W'(n);
      #1;
      chk({tag, ":tc_pre"}, {31'd0, tc_saida}, {31'd0, e && (model == 0)});
      @(posedge clk);
      model = next_digit(model, c, l, e, n);
      #1;
      chk({tag, ":count"}, {28'd0, numero_saida}, model);
      chk({tag, ":zero"}, {31'd0, zero_saida}, {31'd0, model == 0});
      chk({tag, ":tc"}, {31'd0, tc_saida}, {31'd0, e && (model == 0)});
      if (tc_saida) tc_seen++;
   endtask

   initial begin
      clear  = 1'b1;
      load   = 1'b1;
      enab   = 1'b1;
      numero = '0;
      repeat (2) @(posedge clk);
      #1;
      model = 0;
      chk("reset:count", {28'd0, numero_saida}, 0);
      chk("reset:zero", {31'd0, zero_saida}, 1);
      chk("reset:tc", {31'd0, tc_saida}, 1);
      enab = 1'b0;
      #1;
      chk("reset:tc_noenab", {31'd0, tc_saida}, 0);

      step("load5", 1'b0, 1'b0, 1'b0, 5);
      for (int i = 0; i < 5; i++) step("down", 1'b0, 1'b1, 1'b1, 0);
      chk("down:final", {28'd0, numero_saida}, 0);

      step("wrap", 1'b0, 1'b1, 1'b1, 0);
      chk("wrap:is9", {28'd0, numero_saida}, 9);
      for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b1, 1'b0, 0);
      chk("hold:is9", {28'd0, numero_saida}, 9);

      tc_seen = 0;
      for (int i = 0; i < 10; i++) step("cycle", 1'b0, 1'b1, 1'b1, 0);
      chk("cycle:tc_once", tc_seen, 1);
      chk("cycle:back9", {28'd0, numero_saida}, 9);

      step("sat12", 1'b0, 1'b0, 1'b1, 12);
      step("sat15", 1'b0, 1'b0, 1'b0, 15);
      chk("sat:is9", {28'd0, numero_saida}, 9);

      step("prio_clear", 1'b1, 1'b0, 1'b1, 7);
      chk("prio_clear:is0", {28'd0, numero_saida}, 0);
      step("prio_load", 1'b0, 1'b0, 1'b1, 3);
      chk("prio_load:is3", {28'd0, numero_saida}, 3);

      step("midclear", 1'b1, 1'b1, 1'b1, 0);
      step("resume", 1'b0, 1'b1, 1'b1, 0);
      chk("resume:is9", {28'd0, numero_saida}, 9);

      for (int i = 0; i < 400; i++) begin
         bit c;
         bit l;
         bit e;
         c = ($urandom_range(0, 15) == 0);
         l = ($urandom_range(0, 7) != 0);
         e = ($urandom_range(0, 3) != 0);
         step("rand", c, l, e, int'($urandom_range(0, 15)));
         chk("rand:range", {31'd0, numero_saida < W'(M)}, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
